// File: rtl/text_writer_if.sv
// rtl/text_writer_if.sv - byte input handshake and character RAM write port for text_writer
interface text_writer_if #(
    parameter int ADDR_W = 12
);
    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output char_valid, char_data,
        input  char_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/text_writer.sv
// rtl/text_writer.sv - cursor tracking and character RAM writer for the VGA text buffer
module text_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 40,
    parameter int ADDR_W = 12
) (
    input  logic        clock100,
    input  logic        reset,
    text_writer_if.slave bus,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
    localparam logic [5:0]        ROW_LAST  = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    state_t            state, state_nx;
    logic [6:0]        col_nx;
    logic [5:0]        row_nx;
    logic [ADDR_W-1:0] lin, lin_nx, addr_nx;
    logic              en_nx;
    logic [7:0]        data_nx;
    logic              accept;

    assign bus.char_ready = (state == IDLE);
    assign busy           = (state != IDLE);
    assign accept         = bus.char_valid && bus.char_ready;

    always_comb begin
        state_nx = state;
        col_nx   = cursor_col;
        row_nx   = cursor_row;
        lin_nx   = lin;
        en_nx    = bus.wr_en;
        addr_nx  = bus.wr_addr;
        data_nx  = bus.wr_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
                        en_nx    = 1'b1;
                        addr_nx  = lin;
                        data_nx  = bus.char_data;
                        state_nx = WRITE;
                        if (cursor_col == COL_LAST) begin
                            col_nx = '0;
                            if (cursor_row == ROW_LAST) begin
                                row_nx = '0;
                                lin_nx = '0;
                            end else begin
                                row_nx = cursor_row + 6'd1;
                                lin_nx = lin + 1'b1;
                            end
                        end else begin
                            col_nx = cursor_col + 7'd1;
                            lin_nx = lin + 1'b1;
                        end
                    end else begin
                        case (bus.char_data)
                            8'h0D: begin
                                col_nx = '0;
                                lin_nx = lin - ADDR_W'(cursor_col);
                            end
                            8'h0A: begin
                                col_nx = '0;
                                if (cursor_row == ROW_LAST) begin
                                    row_nx = '0;
                                    lin_nx = '0;
                                end else begin
                                    row_nx = cursor_row + 6'd1;
                                    lin_nx = lin + (COLS_A - ADDR_W'(cursor_col));
                                end
                            end
                            8'h08: begin
                                // Backspace stops at column 0; it never climbs to the previous row.
                                if (cursor_col != '0) begin
                                    col_nx   = cursor_col - 7'd1;
                                    lin_nx   = lin - 1'b1;
                                    en_nx    = 1'b1;
                                    addr_nx  = lin - 1'b1;
                                    data_nx  = 8'h20;
                                    state_nx = WRITE;
                                end
                            end
                            8'h0C: begin
                                col_nx   = '0;
                                row_nx   = '0;
                                lin_nx   = '0;
                                en_nx    = 1'b1;
                                addr_nx  = '0;
                                data_nx  = 8'h20;
                                state_nx = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                en_nx    = 1'b0;
                state_nx = IDLE;
            end
            CLEAR: begin
                // The write address doubles as the clear counter.
                if (bus.wr_addr == ADDR_LAST) begin
                    en_nx    = 1'b0;
                    state_nx = IDLE;
                end else begin
                    addr_nx = bus.wr_addr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cursor_col  <= '0;
            cursor_row  <= '0;
            lin         <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            state       <= state_nx;
            cursor_col  <= col_nx;
            cursor_row  <= row_nx;
            lin         <= lin_nx;
            bus.wr_en   <= en_nx;
            bus.wr_addr <= addr_nx;
            bus.wr_data <= data_nx;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - directed self-checking bench for text_writer
module tb_text_writer;

    logic       clk;
    logic       rst;
    logic [6:0] col;
    logic [5:0] row;
    logic       busy;

    int n_cmp;
    int n_bad;
    int wr_count;

    text_writer_if #(.ADDR_W(12)) bus ();

    text_writer #(.COLS(80), .ROWS(40), .ADDR_W(12)) dut (
        .clock100   (clk),
        .reset      (rst),
        .bus        (bus),
        .cursor_col (col),
        .cursor_row (row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.wr_en) wr_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offers a byte and returns 1 time unit after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        while (!bus.char_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", 32'(bus.char_ready), 32'd1);
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input int addr, input logic [7:0] data);
        check({tag, "_en"},   32'(bus.wr_en),   32'd1);
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'(addr));
        check({tag, "_data"}, 32'(bus.wr_data), 32'(data));
    endtask

    task automatic check_cursor(input string tag, input int c, input int r);
        check({tag, "_col"}, 32'(col), 32'(c));
        check({tag, "_row"}, 32'(row), 32'(r));
    endtask

    initial begin
        int snap;
        int bad;
        n_cmp    = 0;
        n_bad    = 0;
        wr_count = 0;
        rst      = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",   32'(bus.wr_en),      32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr),    32'd0);
        check("rst_wr_data", 32'(bus.wr_data),    32'd0);
        check_cursor("rst", 0, 0);
        check("rst_busy",    32'(busy),           32'd0);
        check("rst_ready",   32'(bus.char_ready), 32'd1);
        rst = 1'b0;

        // single printable
        send(8'h41);
        check_write("a", 0, 8'h41);
        check_cursor("a", 1, 0);
        check("a_ready_low", 32'(bus.char_ready), 32'd0);
        @(posedge clk);
        #1;
        check("a_en_drop",   32'(bus.wr_en),      32'd0);
        check("a_ready_hi",  32'(bus.char_ready), 32'd1);
        check("a_count",     32'(wr_count),       32'd1);

        // row crossing
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(8'(8'h61 + i % 26));
            if (i == 79) begin
                check_write("row80", 79, 8'(8'h61 + 79 % 26));
                check_cursor("row80", 0, 1);
            end
        end
        send(8'h5A);
        check_write("z", 80, 8'h5A);
        check_cursor("z", 1, 1);

        // last cell and screen wrap
        do_reset();
        snap = wr_count;
        for (int i = 0; i < 39; i++) send(8'h0A);
        check("lf_ready", 32'(bus.char_ready), 32'd1);
        check("lf_nowr",  32'(wr_count),       32'(snap));
        check_cursor("lf39", 0, 39);
        for (int i = 0; i < 79; i++) send(8'h2E);
        check_write("pre_q", 3198, 8'h2E);
        check_cursor("pre_q", 79, 39);
        send(8'h51);
        check_write("q", 3199, 8'h51);
        check_cursor("q", 0, 0);

        // backspace
        do_reset();
        send(8'h41);
        send(8'h42);
        send(8'h08);
        check_write("bs1", 1, 8'h20);
        check_cursor("bs1", 1, 0);
        send(8'h08);
        check_write("bs2", 0, 8'h20);
        check_cursor("bs2", 0, 0);
        @(posedge clk);
        #1 snap = wr_count;
        send(8'h08);
        check("bs3_en",    32'(bus.wr_en),      32'd0);
        check("bs3_ready", 32'(bus.char_ready), 32'd1);
        check_cursor("bs3", 0, 0);
        @(posedge clk);
        #1 check("bs3_nowr", 32'(wr_count), 32'(snap));

        // CR / LF / ignored bytes
        do_reset();
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        @(posedge clk);
        #1 snap = wr_count;
        send(8'h0D);
        check("cr_ready", 32'(bus.char_ready), 32'd1);
        check_cursor("cr", 0, 0);
        send(8'h0A);
        check("lf_ready2", 32'(bus.char_ready), 32'd1);
        check_cursor("lf", 0, 1);
        send(8'h7F);
        send(8'h00);
        send(8'hC3);
        check_cursor("ign", 0, 1);
        check("crlf_nowr", 32'(wr_count), 32'(snap));
        send(8'h6B);
        check_write("k", 80, 8'h6B);
        check_cursor("k", 1, 1);
        send(8'h6D);
        send(8'h0A);
        check_cursor("lf_mid", 0, 2);
        send(8'h6E);
        check_write("lf_mid_n", 160, 8'h6E);

        // form feed: full clear, char_valid held high throughout
        send(8'h0C);
        check_write("ff0", 0, 8'h20);
        check_cursor("ff0", 0, 0);
        check("ff0_busy", 32'(busy), 32'd1);
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h58;
        bad = 0;
        for (int k = 1; k < 3200; k++) begin
            @(posedge clk);
            #1;
            if (!bus.wr_en || bus.wr_addr != 12'(k) || bus.wr_data != 8'h20 || bus.char_ready)
                bad++;
        end
        check("ff_seq", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        check("ff_end_en",   32'(bus.wr_en), 32'd0);
        check("ff_end_busy", 32'(busy),      32'd0);
        check_cursor("ff_end", 0, 0);
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
        check_write("ff_x", 0, 8'h58);
        check_cursor("ff_x", 1, 0);

        // reset in the middle of a clear
        @(posedge clk);
        #1;
        send(8'h0C);
        repeat (1000) @(posedge clk);
        #1 check("mid_addr", 32'(bus.wr_addr), 32'd1000);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en",   32'(bus.wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy),      32'd0);
        check_cursor("mid_rst", 0, 0);
        snap = wr_count;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("mid_rst_nowr", 32'(wr_count), 32'(snap));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
